// File: rtl/count_monitor_pkg.sv
// Shared types for the count monitor: event encoding, monitor FSM states and
// the event record that is queued towards the debug/status consumer.
// No logic lives here; the enums fix the software-visible encodings.
package count_monitor_pkg;

    // Width of the data field carried in an event record.
    localparam int EVT_DATA_W = 4;

    // Encoding visible to software on EVT_TYPE.
    typedef enum logic [1:0] {
        EVT_MATCH   = 2'd0,
        EVT_WRAP    = 2'd1,
        EVT_RESTART = 2'd2,
        EVT_JUMP    = 2'd3
    } evt_type_e;

    // Monitor FSM: PRIME exists so the first sample after enable only seeds prev.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_TRACK = 2'd2
    } mon_state_e;

    // One queued event: what happened and the count value seen when it happened.
    typedef struct packed {
        evt_type_e               typ;
        logic [EVT_DATA_W-1:0]   data;
    } evt_rec_t;

endpackage

// File: rtl/count_monitor_evt_fifo.sv
// Small first-word-fall-through FIFO with occupancy output and sync clear.
// Latency: a push at edge N is visible on dat_o/vld_o right after edge N when empty.
// Backpressure: push is refused when full unless a pop happens the same cycle.
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              dat_i,
    input  logic                       pop_i,
    output logic                       vld_o,
    output logic [DW-1:0]              dat_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);

    assign vld_o   = !empty;
    assign dat_o   = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o = cnt_q;

    // Pointer and occupancy next-state; clear empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ONE_PTR;
            if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + ONE_CNT;
                2'b01:   cnt_d = cnt_q - ONE_CNT;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Watches a free-running up-counter, classifies each step and queues events.
// Latency: sample at edge N is classified and written to the event FIFO at edge N.
// Backpressure: consumer stalls via EVT_READY; events arriving while full are dropped (OVF).
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH  = EVT_DATA_W,
    parameter int DEPTH  = 4,
    parameter int WCNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic                     CLR,
    input  logic [WIDTH-1:0]         Q_IN,
    input  logic [WIDTH-1:0]         MATCH_VAL,
    input  logic                     EVT_READY,
    output logic                     EVT_VALID,
    output logic [1:0]               EVT_TYPE,
    output logic [WIDTH-1:0]         EVT_DATA,
    output logic [WCNT_W-1:0]        WRAP_CNT,
    output logic                     ERR,
    output logic                     OVF,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);

    mon_state_e         state_q, state_d;
    logic               prime_act;
    logic               track_act;

    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   step;
    logic               is_hold;
    logic               is_one;
    logic               q_zero;
    logic               is_wrap;
    logic               is_restart;
    logic               is_jump;
    logic               is_match;
    logic               evt_vld;
    evt_rec_t           evt_rec;
    evt_rec_t           head_rec;
    logic               push;
    logic               pop;
    logic               fifo_full;

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: dropping EN always returns to IDLE so re-enable re-primes.
    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: state_d = ST_TRACK;
                ST_TRACK: state_d = ST_TRACK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: which kind of sampling this edge performs.
    always_comb begin
        prime_act = EN && (state_q == ST_PRIME);
        track_act = EN && (state_q == ST_TRACK);
    end

    // Step classification against the previous sample, then priority select.
    always_comb begin
        step       = Q_IN - prev_q;
        is_hold    = (step == '0);
        is_one     = (step == STEP_ONE);
        q_zero     = (Q_IN == '0);
        is_wrap    = is_one && q_zero && (prev_q == '1);
        is_restart = q_zero && !is_hold && !is_one;
        is_jump    = !q_zero && !is_hold && !is_one;
        is_match   = (Q_IN == MATCH_VAL) && !is_hold;

        evt_vld      = track_act && (is_jump || is_wrap || is_restart || is_match);
        evt_rec.data = EVT_DATA_W'(Q_IN);
        if (is_jump)         evt_rec.typ = EVT_JUMP;
        else if (is_wrap)    evt_rec.typ = EVT_WRAP;
        else if (is_restart) evt_rec.typ = EVT_RESTART;
        else                 evt_rec.typ = EVT_MATCH;
    end

    assign push = evt_vld && !CLR;
    assign pop  = EVT_VALID && EVT_READY;

    // Previous-sample, wrap counter and sticky flag next-state.
    always_comb begin
        prev_d = prev_q;
        wcnt_d = wcnt_q;
        err_d  = err_q;
        ovf_d  = ovf_q;
        if (prime_act || track_act) prev_d = Q_IN;
        if (CLR) begin
            wcnt_d = '0;
            err_d  = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (track_act && is_wrap && (wcnt_q != '1)) wcnt_d = wcnt_q + WCNT_W'(1);
            if (track_act && is_jump) err_d = 1'b1;
            if (push && fifo_full && !pop) ovf_d = 1'b1;
        end
    end

    // Monitor state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q <= '0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(evt_rec_t))
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clr_i   (CLR),
        .push_i  (push),
        .dat_i   (evt_rec),
        .pop_i   (pop),
        .vld_o   (EVT_VALID),
        .dat_o   (head_rec),
        .full_o  (fifo_full),
        .level_o (LEVEL)
    );

    assign EVT_TYPE = head_rec.typ;
    assign EVT_DATA = WIDTH'(head_rec.data);
    assign WRAP_CNT = wcnt_q;
    assign ERR      = err_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with a queue-based reference model.
// Every clock the model is advanced at the rising edge and all outputs compared on the falling edge.
// Literal expectations at key points pin the model to hand-derived values.
module tb_count_monitor;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic       CLR;
    logic [3:0] Q_IN;
    logic [3:0] MATCH_VAL;
    logic       EVT_READY;
    logic       EVT_VALID;
    logic [1:0] EVT_TYPE;
    logic [3:0] EVT_DATA;
    logic [7:0] WRAP_CNT;
    logic       ERR;
    logic       OVF;
    logic [2:0] LEVEL;

    count_monitor #(.WIDTH(4), .DEPTH(DEPTH), .WCNT_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .CLR       (CLR),
        .Q_IN      (Q_IN),
        .MATCH_VAL (MATCH_VAL),
        .EVT_READY (EVT_READY),
        .EVT_VALID (EVT_VALID),
        .EVT_TYPE  (EVT_TYPE),
        .EVT_DATA  (EVT_DATA),
        .WRAP_CNT  (WRAP_CNT),
        .ERR       (ERR),
        .OVF       (OVF),
        .LEVEL     (LEVEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int t;
        int d;
    } ev_t;

    ev_t mq[$];
    int  m_run;
    int  m_prev;
    int  m_wcnt;
    int  m_err;
    int  m_ovf;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run  = 0;
        m_prev = 0;
        m_wcnt = 0;
        m_err  = 0;
        m_ovf  = 0;
    endtask

    // Reference behaviour for one rising edge, from the step rules.
    task automatic model_edge();
        int  qv, mv, d, et;
        bit  has, do_pop;
        if (RESET) begin
            model_reset();
            return;
        end
        qv  = int'(Q_IN);
        mv  = int'(MATCH_VAL);
        has = 1'b0;
        et  = 0;
        do_pop = EVT_READY && (mq.size() > 0);
        if (!EN) m_run = 0;
        else if (m_run < 3) m_run++;
        if (EN && m_run == 2) begin
            m_prev = qv;
        end else if (EN && m_run >= 3) begin
            d = (qv - m_prev + 16) % 16;
            if (d > 1 && qv != 0)            begin has = 1; et = 3; end
            else if (d == 1 && qv == 0)      begin has = 1; et = 1; end
            else if (d > 1 && qv == 0)       begin has = 1; et = 2; end
            else if (d != 0 && qv == mv)     begin has = 1; et = 0; end
            m_prev = qv;
        end
        if (CLR) begin
            mq.delete();
            m_wcnt = 0;
            m_err  = 0;
            m_ovf  = 0;
        end else begin
            if (has && et == 1 && m_wcnt < 255) m_wcnt++;
            if (has && et == 3) m_err = 1;
            if (do_pop) void'(mq.pop_front());
            if (has) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else mq.push_back('{t: et, d: qv});
            end
        end
    endtask

    task automatic compare_all();
        bit vld;
        vld = (mq.size() > 0);
        chk("evt_valid", int'(EVT_VALID), int'(vld));
        chk("evt_type",  int'(EVT_TYPE),  vld ? mq[0].t : 0);
        chk("evt_data",  int'(EVT_DATA),  vld ? mq[0].d : 0);
        chk("level",     int'(LEVEL),     mq.size());
        chk("wrap_cnt",  int'(WRAP_CNT),  m_wcnt);
        chk("err",       int'(ERR),       m_err);
        chk("ovf",       int'(OVF),       m_ovf);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic stepq(input int q);
        Q_IN = 4'(q);
        step();
    endtask

    initial begin
        int seq_a[6];
        int seq_b[4];
        RESET = 1'b1; EN = 1'b0; CLR = 1'b0; Q_IN = '0; MATCH_VAL = '0; EVT_READY = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_valid", int'(EVT_VALID), 0);
        chk("rst_type",  int'(EVT_TYPE),  0);
        chk("rst_data",  int'(EVT_DATA),  0);
        chk("rst_level", int'(LEVEL),     0);
        chk("rst_wcnt",  int'(WRAP_CNT),  0);
        chk("rst_err",   int'(ERR),       0);
        chk("rst_ovf",   int'(OVF),       0);
        RESET = 1'b0;

        // Counter sweep with a match value and one wrap.
        MATCH_VAL = 4'd9; EN = 1'b1;
        for (int i = 0; i < 18; i++) stepq(i % 16);
        chk("t1_level", int'(LEVEL), 2);
        chk("t1_type0", int'(EVT_TYPE), 0);
        chk("t1_data0", int'(EVT_DATA), 9);
        chk("t1_wcnt",  int'(WRAP_CNT), 1);
        chk("t1_err",   int'(ERR), 0);
        EVT_READY = 1'b1; step(); EVT_READY = 1'b0;
        chk("t1_type1", int'(EVT_TYPE), 1);
        chk("t1_data1", int'(EVT_DATA), 0);
        EVT_READY = 1'b1; step(); EVT_READY = 1'b0;

        // Illegal step 5 -> 9, sticky error, then clear.
        for (int i = 2; i <= 5; i++) stepq(i);
        stepq(9);
        chk("t2_type", int'(EVT_TYPE), 3);
        chk("t2_data", int'(EVT_DATA), 9);
        chk("t2_err",  int'(ERR), 1);
        step(); step();
        chk("t2_err_sticky", int'(ERR), 1);
        CLR = 1'b1; step(); CLR = 1'b0;
        chk("t2_err_clr",   int'(ERR), 0);
        chk("t2_level_clr", int'(LEVEL), 0);

        // Counter restart versus a genuine wrap.
        MATCH_VAL = 4'd0;
        stepq(0);
        for (int i = 1; i <= 6; i++) stepq(i);
        CLR = 1'b1; step(); CLR = 1'b0;
        stepq(0);
        chk("t3_level", int'(LEVEL), 1);
        chk("t3_type",  int'(EVT_TYPE), 2);
        chk("t3_data",  int'(EVT_DATA), 0);
        chk("t3_err",   int'(ERR), 0);
        for (int i = 1; i <= 16; i++) stepq(i % 16);
        chk("t3_level2", int'(LEVEL), 2);
        chk("t3_wcnt",   int'(WRAP_CNT), 1);
        EVT_READY = 1'b1; step(); EVT_READY = 1'b0;
        chk("t3_wrap_type", int'(EVT_TYPE), 1);
        EVT_READY = 1'b1; step(); EVT_READY = 1'b0;

        // Overflow with a stalled consumer, then push and pop while full.
        CLR = 1'b1; step(); CLR = 1'b0;
        seq_a = '{3, 7, 11, 14, 5, 9};
        for (int i = 0; i < 4; i++) stepq(seq_a[i]);
        chk("t4_level4", int'(LEVEL), 4);
        chk("t4_noovf",  int'(OVF), 0);
        stepq(seq_a[4]);
        chk("t4_ovf",    int'(OVF), 1);
        chk("t4_head",   int'(EVT_DATA), 3);
        EVT_READY = 1'b1; stepq(seq_a[5]); EVT_READY = 1'b0;
        chk("t4_pp_level", int'(LEVEL), 4);
        chk("t4_pp_ovf",   int'(OVF), 1);
        chk("t4_pp_head",  int'(EVT_DATA), 7);
        CLR = 1'b1; step(); CLR = 1'b0;
        seq_b = '{12, 1, 4, 8};
        for (int i = 0; i < 4; i++) stepq(seq_b[i]);
        EVT_READY = 1'b1; stepq(13);
        chk("t4_pp2_level", int'(LEVEL), 4);
        chk("t4_pp2_ovf",   int'(OVF), 0);
        chk("t4_pp2_head",  int'(EVT_DATA), 1);
        for (int i = 0; i < 4; i++) step();
        EVT_READY = 1'b0;

        // Gap in enable: a jump while idle must not be flagged, FIFO still drains.
        MATCH_VAL = 4'd4;
        CLR = 1'b1; stepq(3); CLR = 1'b0;
        stepq(4); stepq(0); stepq(1); stepq(2); stepq(3);
        chk("t5_level", int'(LEVEL), 2);
        EN = 1'b0; EVT_READY = 1'b1;
        for (int i = 0; i < 3; i++) stepq(12);
        chk("t5_drained", int'(LEVEL), 0);
        EN = 1'b1; EVT_READY = 1'b0;
        for (int i = 0; i < 3; i++) stepq(12);
        stepq(13);
        chk("t5_err",   int'(ERR), 0);
        chk("t5_level2", int'(LEVEL), 0);

        // Seven wraps, three queued events, then asynchronous reset mid-cycle.
        CLR = 1'b1; step(); CLR = 1'b0;
        MATCH_VAL = 4'd5; EVT_READY = 1'b1;
        for (int i = 14; i <= 112; i++) stepq(i % 16);
        stepq(0);
        EVT_READY = 1'b0;
        stepq(3); stepq(7); stepq(11);
        chk("t6_level", int'(LEVEL), 3);
        chk("t6_wcnt",  int'(WRAP_CNT), 7);
        #2 RESET = 1'b1;
        #1;
        chk("t6_rst_valid", int'(EVT_VALID), 0);
        chk("t6_rst_level", int'(LEVEL), 0);
        chk("t6_rst_wcnt",  int'(WRAP_CNT), 0);
        chk("t6_rst_err",   int'(ERR), 0);
        model_reset();
        step();
        RESET = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream consumer of the free-running 4-bit up-counter; samples its Q every clock.
- Checks that the count sequence is legal, counts wrap-arounds and detects a programmable match value.
- Pushes timestamp-free event records into a small FIFO drained by a valid/ready consumer (debug/status logic).
- Provides sticky error and overflow flags for software polling.

Parameters:
- WIDTH, 4: width of the monitored count and of the match value.
- DEPTH, 4: event FIFO entries; power of two, 2..16.
- WCNT_W, 8: width of the wrap counter; saturates.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  monitor enable; 0 = idle, no checking.
- CLR  in  1  synchronous clear of flags, wrap count and FIFO.
- Q_IN  in  WIDTH  counter output being monitored.
- MATCH_VAL  in  WIDTH  value that raises a MATCH event.
- EVT_READY  in  1  consumer accepts the head event.
- EVT_VALID  out  1  FIFO non-empty; head event presented.
- EVT_TYPE  out  2  head event type.
- EVT_DATA  out  WIDTH  Q_IN value captured with the head event.
- WRAP_CNT  out  WCNT_W  saturating count of 15->0 wraps.
- ERR  out  1  sticky: an illegal step (JUMP) was seen.
- OVF  out  1  sticky: an event was dropped because the FIFO was full.
- LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; prev=0.
  - FIFO empty: EVT_VALID=0, EVT_TYPE=0, EVT_DATA=0, LEVEL=0.
  - WRAP_CNT=0, ERR=0, OVF=0.
- FSM states:
  - IDLE: leaves to PRIME when EN=1.
  - PRIME: latches Q_IN into prev, generates no event, goes to TRACK.
  - TRACK: checks every sample.
  - EN=0 in any state returns to IDLE next edge. Re-enable always re-primes, so there is no false JUMP across a gap.
- TRACK classification each edge, with d = (Q_IN - prev) mod 2^WIDTH:
  - d=0: hold, legal, no event.
  - d=1 and prev=MAX, Q_IN=0: WRAP. WRAP_CNT+1, saturating at all-ones.
  - d=1 otherwise: legal increment.
  - Q_IN=0 and d>1: RESTART (counter was reset). Legal, no ERR.
  - Any other d: JUMP. ERR<=1.
  - MATCH: Q_IN==MATCH_VAL and d!=0 (edge-qualified, not level).
  - prev<=Q_IN every TRACK edge.
- At most one event is pushed per cycle. Priority JUMP(3) > WRAP(1) > RESTART(2) > MATCH(0). A MATCH coincident with a higher-priority event is suppressed; that event's EVT_DATA already equals Q_IN.
- Encoding: EVT_TYPE 0=MATCH, 1=WRAP, 2=RESTART, 3=JUMP.
- Latency: Q_IN sampled at edge N yields the FIFO write at edge N. EVT_VALID is high after edge N when the FIFO was empty.
- FIFO rules:
  - First-word-fall-through; pop on EVT_VALID & EVT_READY.
  - Push when full and no pop: event dropped, OVF<=1, contents unchanged.
  - Push and pop in the same cycle when full: both happen, LEVEL stays DEPTH, no OVF.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- EN=0: no pushes; the FIFO keeps draining normally.
- CLR=1: empties the FIFO and zeroes WRAP_CNT, ERR and OVF. No push that cycle. FSM state is unaffected.
- RESET asserted mid-operation: every output returns to its reset value immediately; pending events are lost.

Decomposition:
- Package count_monitor_pkg:
  - evt_type_e enum (MATCH, WRAP, RESTART, JUMP).
  - mon_state_e enum (IDLE, PRIME, TRACK).
  - Event record struct {type, data}.
- Sub-module evt_fifo (parameterised DEPTH and data width, FWFT, level output).
- Classification and FSM live in count_monitor.

Test Plan:
- Reset, then EN=1, Q_IN stepping 0..15,0,1 one per clock, MATCH_VAL=9 -> one MATCH(data 9) then WRAP(data 0); WRAP_CNT=1, ERR=0.
- In TRACK, Q_IN 5 -> 9 -> JUMP(data 9), ERR=1 and stays 1 until CLR. CLR pulse -> ERR=0, LEVEL=0.
- Q_IN 6 -> 0 (counter reset) -> RESTART(data 0), ERR=0. Q_IN 15 -> 0 -> WRAP (not RESTART).
- EVT_READY=0 with DEPTH=4, generate 5 events -> LEVEL=4, OVF=1, first four retained in order. Then full-plus-simultaneous push/pop -> LEVEL=4 and OVF unchanged.
- EN=0 while Q_IN jumps 3 -> 12, then EN=1 -> no JUMP event, ERR=0. The FIFO drains while EN=0.
- Assert RESET asynchronously mid-cycle with LEVEL=3 and WRAP_CNT=7 -> EVT_VALID=0, LEVEL=0, WRAP_CNT=0 before the next CLK edge.
